// File: rtl/pipe_pkg.sv
// Shared state encoding and constants for the pipeline stage register.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_t;

    localparam int unsigned EXC_NONE = 0;
    localparam int unsigned STALL_W  = 16;
endpackage

// File: rtl/pipe_slot.sv
// One storage entry (valid, pc, data, exc) with load and clear; clear wins.
// Latency: 1 cycle from load to outputs.
// Backpressure: none; the owner decides when to load or clear.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int              PC_W    = 32,
    parameter int              DATA_W  = 32,
    parameter int              EXC_W   = 5,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [PC_W-1:0]   d_pc,
    input  logic [DATA_W-1:0] d_data,
    input  logic [EXC_W-1:0]  d_exc,
    output logic              valid,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] data,
    output logic [EXC_W-1:0]  exc
);

    // Fields are cleared together with valid so an empty slot already shows NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            pc    <= '0;
            data  <= NOP_VAL;
            exc   <= EXC_W'(EXC_NONE);
        end else if (clear) begin
            valid <= 1'b0;
            pc    <= '0;
            data  <= NOP_VAL;
            exc   <= EXC_W'(EXC_NONE);
        end else if (load) begin
            valid <= 1'b1;
            pc    <= d_pc;
            data  <= d_data;
            exc   <= d_exc;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and stall counter; PIPE_STAGE_SKID_EN adds a skid entry.
// Latency: 1 cycle from accept into an empty stage to out_*.
// Backpressure: in_ready drops when full (skid build: registered, no out_ready->in_ready path) or on flush.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W  = 32,
    parameter int                PC_W    = 32,
    parameter int                EXC_W   = 5,
    parameter logic [DATA_W-1:0] NOP_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [DATA_W-1:0]  in_data,
    input  logic [EXC_W-1:0]   in_exc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [DATA_W-1:0]  out_data,
    output logic [EXC_W-1:0]   out_exc,
    output logic [STALL_W-1:0] stall_cnt
);

    pipe_state_t       state, state_nxt;
    logic              rdy_en;
    logic              accept, drain;
    logic              head_load, head_clear;
    logic [PC_W-1:0]   head_d_pc;
    logic [DATA_W-1:0] head_d_data;
    logic [EXC_W-1:0]  head_d_exc;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // rdy_en keeps in_ready low until the first edge after reset is released.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= EMPTY;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = ONE;
                ONE: begin
                    if (drain && !accept) state_nxt = EMPTY;
`ifdef PIPE_STAGE_SKID_EN
                    else if (accept && !drain) state_nxt = TWO;
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: if (drain) state_nxt = ONE;
`endif
                default: state_nxt = EMPTY;
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    logic              head_from_skid, skid_load, skid_clear, skid_valid;
    logic [PC_W-1:0]   skid_pc;
    logic [DATA_W-1:0] skid_data;
    logic [EXC_W-1:0]  skid_exc;
`endif

    always_comb begin
        head_load  = 1'b0;
        head_clear = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
        head_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clear     = 1'b0;
`endif
        if (flush) begin
            head_clear = 1'b1;
`ifdef PIPE_STAGE_SKID_EN
            skid_clear = 1'b1;
`endif
        end else begin
            case (state)
                EMPTY: head_load = accept;
                ONE: begin
                    if (drain) begin
                        head_load  = accept;
                        head_clear = !accept;
                    end
`ifdef PIPE_STAGE_SKID_EN
                    else skid_load = accept;
`endif
                end
`ifdef PIPE_STAGE_SKID_EN
                TWO: if (drain) begin
                    head_load      = 1'b1;
                    head_from_skid = 1'b1;
                    skid_clear     = 1'b1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    assign in_ready    = rdy_en && (state != TWO) && !flush;
    assign head_d_pc   = head_from_skid ? skid_pc   : in_pc;
    assign head_d_data = head_from_skid ? skid_data : in_data;
    assign head_d_exc  = head_from_skid ? skid_exc  : in_exc;

    pipe_slot #(.PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W), .NOP_VAL(NOP_VAL)) u_skid (
        .clk(clk), .reset(reset), .load(skid_load), .clear(skid_clear),
        .d_pc(in_pc), .d_data(in_data), .d_exc(in_exc),
        .valid(skid_valid), .pc(skid_pc), .data(skid_data), .exc(skid_exc)
    );

    // The skid slot is occupied exactly when the FSM sits in TWO.
    always_ff @(posedge clk) begin
        if (reset) assert (skid_valid == (state == TWO));
    end
`else
    assign in_ready    = rdy_en && (!out_valid || out_ready) && !flush;
    assign head_d_pc   = in_pc;
    assign head_d_data = in_data;
    assign head_d_exc  = in_exc;
`endif

    pipe_slot #(.PC_W(PC_W), .DATA_W(DATA_W), .EXC_W(EXC_W), .NOP_VAL(NOP_VAL)) u_head (
        .clk(clk), .reset(reset), .load(head_load), .clear(head_clear),
        .d_pc(head_d_pc), .d_data(head_d_data), .d_exc(head_d_exc),
        .valid(out_valid), .pc(out_pc), .data(out_data), .exc(out_exc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + STALL_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: queue-based reference model, random and directed traffic.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic [4:0]  exc;
    } ent_t;

    logic        clk, reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_pc, in_data, out_pc, out_data;
    logic [4:0]  in_exc, out_exc;
    logic [15:0] stall_cnt;

    int   n_cmp = 0;
    int   n_err = 0;
    ent_t q[$];
    int   m_stall = 0;
    bit   m_rdy = 0;
    logic took;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_data(in_data), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_data(out_data), .out_exc(out_exc),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_rdy(input logic ordy, input logic fl);
        if (!m_rdy || fl) return 1'b0;
        if (SKID) return q.size() < 2;
        return (q.size() == 0) || ordy;
    endfunction

    // Called at a negedge; drives one cycle, checks outputs, advances the model.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] data,
                         input logic [4:0] exc, input logic ordy, input logic fl,
                         output logic acc);
        logic er;
        ent_t h;
        bit   busy;
        in_valid = v; in_pc = pc; in_data = data; in_exc = exc;
        out_ready = ordy; flush = fl;
        #1;
        er   = exp_rdy(ordy, fl);
        busy = q.size() > 0;
        h    = busy ? q[0] : '0;
        check_val("in_ready", in_ready, er);
        check_val("out_valid", out_valid, busy);
        check_val("out_pc", out_pc, h.pc);
        check_val("out_data", out_data, h.data);
        check_val("out_exc", out_exc, h.exc);
        check_val("stall_cnt", stall_cnt, m_stall);
        @(posedge clk);
        if (busy && !ordy && m_stall < 65535) m_stall++;
        if (fl) begin
            q.delete();
        end else begin
            if (busy && ordy) void'(q.pop_front());
            if (v && er) q.push_back('{pc: pc, data: data, exc: exc});
        end
        acc = v && er;
        @(negedge clk);
    endtask

    task automatic send_until(input logic [31:0] pc, input logic [31:0] data,
                              input logic [4:0] exc, input logic ordy);
        logic a;
        a = 1'b0;
        for (int k = 0; k < 20 && !a; k++) cycle(1'b1, pc, data, exc, ordy, 1'b0, a);
        check_val("accept_timeout", a, 1'b1);
    endtask

    task automatic async_reset();
        @(negedge clk);
        #3 reset = 1'b0;
        in_valid = 1'b1;
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_out_pc", out_pc, 0);
        check_val("rst_out_exc", out_exc, 0);
        check_val("rst_stall_cnt", stall_cnt, 0);
        check_val("rst_in_ready", in_ready, 0);
        q.delete();
        m_stall = 0;
        m_rdy   = 0;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_val("rel_in_ready", in_ready, 0);
        @(posedge clk);
        m_rdy = 1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = '0; in_data = '0; in_exc = '0;
        #2;
        check_val("init_out_valid", out_valid, 0);
        check_val("init_stall_cnt", stall_cnt, 0);
        check_val("init_in_ready", in_ready, 0);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_val("init_rel_in_ready", in_ready, 0);
        @(posedge clk);
        m_rdy = 1;
        @(negedge clk);

        // Single entry then a continuous stream.
        cycle(1'b1, 32'h3000, 32'h2401_0001, 5'd0, 1'b1, 1'b0, took);
        cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, took);
        check_val("first_pc", out_pc, 32'h0);
        for (int i = 0; i < 8; i++)
            cycle(1'b1, 32'h3100 + 32'(4 * i), $urandom, 5'd0, 1'b1, 1'b0, took);
        cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, took);

        // Exception code travels with its PC, through the skid slot when present.
        cycle(1'b1, 32'h3008, 32'hAAAA_0000, 5'd0, 1'b0, 1'b0, took);
        send_until(32'h3004, 32'h1234_5678, 5'd4, !SKID);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b1, 1'b0, took);

        for (int i = 0; i < 500; i++)
            cycle($urandom_range(99) < 70, $urandom, $urandom, 5'($urandom_range(31)),
                  $urandom_range(99) < 60, $urandom_range(99) < 6, took);

        // Reset asserted mid-traffic with entries held.
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3200 + 32'(i), $urandom, 5'd1, 1'b0, 1'b0, took);
        async_reset();

        // Five backpressure cycles with the stage full.
        cycle(1'b1, 32'h4000, 32'h4000_0000, 5'd0, 1'b1, 1'b0, took);
        for (int i = 0; i < 5; i++)
            cycle(1'b1, 32'h4004 + 32'(4 * i), $urandom, 5'd0, 1'b0, 1'b0, took);
        check_val("stall_cnt_5", stall_cnt, 16'd5);
        check_val("stall_hold_pc", out_pc, 32'h4000);

        // Flush while full (TWO with skid) and offering a new entry.
        cycle(1'b1, 32'h5000, 32'h5000_0000, 5'd3, 1'b0, 1'b1, took);
        check_val("flush_out_valid", out_valid, 0);
        check_val("flush_out_pc", out_pc, 0);
        check_val("flush_out_exc", out_exc, 0);
        check_val("flush_stall_cnt", stall_cnt, 16'd6);
        cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, took);

        // Long backpressure to reach saturation.
        cycle(1'b1, 32'h6000, 32'h6000_0000, 5'd0, 1'b1, 1'b0, took);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        repeat (70000) @(posedge clk);
        m_stall = (m_stall + 70000 > 65535) ? 65535 : m_stall + 70000;
        @(negedge clk);
        check_val("stall_sat", stall_cnt, 16'hFFFF);
        cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, took);
        cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, took);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
